// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP transmit engine between NUM_CH requesters.
// Adds an inter-packet gap and a watchdog that aborts a hung engine.
module udp_tx_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [NUM_CH*16-1:0]   ch_byte_num,
  input  logic [NUM_CH*32-1:0]   ch_data,
  output logic [NUM_CH-1:0]      ch_grant,
  output logic [NUM_CH-1:0]      ch_tx_req,
  output logic [NUM_CH-1:0]      ch_done,
  output logic [NUM_CH-1:0]      ch_err,
  output logic                   tx_start_en,
  output logic [15:0]            tx_byte_num,
  output logic [31:0]            tx_data,
  input  logic                   tx_req,
  input  logic                   tx_done,
  output logic                   busy
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_last;
  logic [NUM_CH-1:0]   r_grant;
  logic [NUM_CH-1:0]   r_done;
  logic [NUM_CH-1:0]   r_err;
  logic                r_start;
  logic [15:0]         r_byte_num;
  logic [15:0]         r_wdog;
  logic [15:0]         r_gap;

  logic                w_any;
  logic [IW-1:0]       w_sel;
  logic [15:0]         w_len;
  logic [31:0]         w_data;
  logic                w_timeout;

  // Search starts one past the last grant, wrapping, so everyone gets a turn.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_len = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      int j;
      j = (int'(r_last) + i) % NUM_CH;
      if (!w_any && ch_req[j]) begin
        w_any = 1'b1;
        w_sel = IW'(j);
        w_len = ch_byte_num[16*j +: 16];
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant[i]) w_data = ch_data[32*i +: 32];
    end
  end

  assign w_timeout = (r_wdog >= 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= IW'(NUM_CH - 1);
      r_grant    <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_start    <= 1'b0;
      r_byte_num <= '0;
      r_wdog     <= '0;
      r_gap      <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
      r_err   <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last <= w_sel;
            if (w_len != 16'd0) begin
              r_state    <= S_BUSY;
              r_grant    <= NUM_CH'(1) << w_sel;
              r_byte_num <= w_len;
              r_start    <= 1'b1;
              r_wdog     <= '0;
            end else begin
              r_err[w_sel] <= 1'b1;
              r_state      <= S_GAP;
              r_gap        <= '0;
            end
          end
        end
        S_BUSY: begin
          if (r_wdog != 16'hFFFF) r_wdog <= r_wdog + 16'd1;
          // Completion takes precedence over a coincident timeout.
          if (tx_done) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_state <= S_GAP;
            r_gap   <= '0;
          end else if (w_timeout) begin
            r_err   <= r_grant;
            r_grant <= '0;
            r_state <= S_GAP;
            r_gap   <= '0;
          end
        end
        S_GAP: begin
          if (r_gap >= 16'(GAP_CYCLES)) r_state <= S_IDLE;
          else                          r_gap   <= r_gap + 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_grant    = r_grant;
  assign ch_tx_req   = r_grant & {NUM_CH{tx_req}};
  assign ch_done     = r_done;
  assign ch_err      = r_err;
  assign tx_start_en = r_start;
  assign tx_byte_num = r_byte_num;
  assign tx_data     = w_data;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: vector table plus multi-cycle sequences.
// Uses GAP_CYCLES=12 and TIMEOUT_CYCLES=100.
module tb_udp_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   ch_req;
  logic [63:0]  ch_byte_num;
  logic [127:0] ch_data;
  logic [3:0]   ch_grant;
  logic [3:0]   ch_tx_req;
  logic [3:0]   ch_done;
  logic [3:0]   ch_err;
  logic         tx_start_en;
  logic [15:0]  tx_byte_num;
  logic [31:0]  tx_data;
  logic         tx_req;
  logic         tx_done;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  udp_tx_arbiter #(
    .NUM_CH(4),
    .GAP_CYCLES(12),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_req(ch_req),
    .ch_byte_num(ch_byte_num),
    .ch_data(ch_data),
    .ch_grant(ch_grant),
    .ch_tx_req(ch_tx_req),
    .ch_done(ch_done),
    .ch_err(ch_err),
    .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num),
    .tx_data(tx_data),
    .tx_req(tx_req),
    .tx_done(tx_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] bn;
    logic        txr;
    logic        dn_in;
    logic [3:0]  g;
    logic        st;
    logic [3:0]  dn;
    logic [3:0]  er;
    logic        bs;
    logic [3:0]  ctr;
    logic [31:0] dat;
    logic [15:0] byt;
  } vec_t;

  vec_t tv [6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40 && busy; t++) tick();
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_g;
    int         exp_ch;
    int         done_cyc;
    logic       err_seen;

    tv[0] = '{4'b0010, {16'd4, 16'd3, 16'd16, 16'd2}, 1'b0, 1'b0,
              4'b0010, 1'b1, 4'b0, 4'b0, 1'b1, 4'b0000, 32'hDEADBEEF, 16'd16};
    tv[1] = '{4'b0010, {16'd4, 16'd3, 16'd16, 16'd2}, 1'b1, 1'b0,
              4'b0010, 1'b0, 4'b0, 4'b0, 1'b1, 4'b0010, 32'hDEADBEEF, 16'd16};
    tv[2] = '{4'b0010, {16'd4, 16'd3, 16'd16, 16'd2}, 1'b0, 1'b0,
              4'b0010, 1'b0, 4'b0, 4'b0, 1'b1, 4'b0000, 32'hDEADBEEF, 16'd16};
    tv[3] = '{4'b0000, {16'd4, 16'd3, 16'd99, 16'd2}, 1'b1, 1'b0,
              4'b0010, 1'b0, 4'b0, 4'b0, 1'b1, 4'b0010, 32'hDEADBEEF, 16'd16};
    tv[4] = '{4'b0000, {16'd4, 16'd3, 16'd99, 16'd2}, 1'b1, 1'b1,
              4'b0000, 1'b0, 4'b0010, 4'b0, 1'b1, 4'b0000, 32'h0, 16'd16};
    tv[5] = '{4'b0000, {16'd4, 16'd3, 16'd99, 16'd2}, 1'b0, 1'b0,
              4'b0000, 1'b0, 4'b0, 4'b0, 1'b1, 4'b0000, 32'h0, 16'd16};

    rst         = 1'b1;
    ch_req      = '0;
    ch_byte_num = '0;
    ch_data     = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111};
    tx_req      = 1'b0;
    tx_done     = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(ch_grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(tx_start_en), 32'd0);
    chk("rst_bytes", 32'(tx_byte_num), 32'd0);
    chk("rst_data", tx_data, 32'd0);
    rst = 1'b0;

    // Vector table: data routing on channel 1 (first pick after reset is 0.. but only 1 requests)
    for (int i = 0; i < 6; i++) begin
      ch_req      = tv[i].req;
      ch_byte_num = tv[i].bn;
      tx_req      = tv[i].txr;
      tx_done     = tv[i].dn_in;
      tick();
      chk($sformatf("v%0d_grant", i), 32'(ch_grant), 32'(tv[i].g));
      chk($sformatf("v%0d_start", i), 32'(tx_start_en), 32'(tv[i].st));
      chk($sformatf("v%0d_done", i), 32'(ch_done), 32'(tv[i].dn));
      chk($sformatf("v%0d_err", i), 32'(ch_err), 32'(tv[i].er));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].bs));
      chk($sformatf("v%0d_txreq", i), 32'(ch_tx_req), 32'(tv[i].ctr));
      chk($sformatf("v%0d_data", i), tx_data, tv[i].dat);
      chk($sformatf("v%0d_bytes", i), 32'(tx_byte_num), 32'(tv[i].byt));
    end
    tx_req  = 1'b0;
    tx_done = 1'b0;
    wait_idle();

    // Single request on channel 0, 64 bytes, done 29 cycles after start
    ch_req      = 4'b0001;
    ch_byte_num = {16'd4, 16'd3, 16'd2, 16'd64};
    tick();
    chk("a_start", 32'(tx_start_en), 32'd1);
    chk("a_bytes", 32'(tx_byte_num), 32'd64);
    chk("a_grant", 32'(ch_grant), 32'b0001);
    tick();
    chk("a_start_pulse", 32'(tx_start_en), 32'd0);
    for (int t = 0; t < 28; t++) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("a_done", 32'(ch_done), 32'b0001);
    chk("a_grant_clr", 32'(ch_grant), 32'd0);
    ch_req = 4'b0000;
    for (int t = 0; t < 12; t++) tick();
    chk("a_gap_busy", 32'(busy), 32'd1);
    tick();
    chk("a_idle", 32'(busy), 32'd0);

    // Zero length on channel 2 is rejected, channel 3 follows
    ch_req      = 4'b0100;
    ch_byte_num = {16'd4, 16'd0, 16'd2, 16'd1};
    tick();
    chk("z_err", 32'(ch_err), 32'b0100);
    chk("z_start", 32'(tx_start_en), 32'd0);
    chk("z_grant", 32'(ch_grant), 32'd0);
    ch_req = 4'b0000;
    tick();
    chk("z_err_once", 32'(ch_err), 32'd0);
    wait_idle();
    ch_req      = 4'b1111;
    ch_byte_num = {16'd4, 16'd3, 16'd2, 16'd1};
    tick();
    chk("z_next", 32'(ch_grant), 32'b1000);
    tick();
    tick();

    // Reset in the middle of a packet
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_grant", 32'(ch_grant), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_done", 32'(ch_done), 32'd0);
    chk("r_err", 32'(ch_err), 32'd0);
    chk("r_bytes", 32'(tx_byte_num), 32'd0);

    // Contention: all four requesting, grants rotate from channel 0
    exp_ch   = 0;
    done_cyc = 0;
    for (int p = 0; p < 5; p++) begin
      for (int t = 0; t < 40 && tx_start_en !== 1'b1; t++) tick();
      chk($sformatf("c%0d_start", p), 32'(tx_start_en), 32'd1);
      exp_g = 4'(1 << exp_ch);
      chk($sformatf("c%0d_grant", p), 32'(ch_grant), 32'(exp_g));
      if (p > 0) chk($sformatf("c%0d_gap", p), 32'(cyc - done_cyc), 32'd14);
      for (int t = 0; t < 19; t++) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk($sformatf("c%0d_done", p), 32'(ch_done), 32'(exp_g));
      done_cyc = cyc;
      exp_ch   = (exp_ch + 1) % 4;
    end
    ch_req = 4'b0000;
    wait_idle();

    // Watchdog: no tx_done, channel 1 aborted 100 cycles after start
    ch_req = 4'b0010;
    tick();
    chk("t_start", 32'(tx_start_en), 32'd1);
    chk("t_grant", 32'(ch_grant), 32'b0010);
    err_seen = 1'b0;
    for (int t = 0; t < 99; t++) begin
      tick();
      if (ch_err != 4'b0) err_seen = 1'b1;
    end
    chk("t_no_early_err", 32'(err_seen), 32'd0);
    tick();
    chk("t_err", 32'(ch_err), 32'b0010);
    chk("t_nodone", 32'(ch_done), 32'd0);
    chk("t_grant_clr", 32'(ch_grant), 32'd0);
    ch_req  = 4'b0000;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t_late_done", 32'(ch_done), 32'd0);
    wait_idle();

    // tx_done coinciding with timeout: done wins
    ch_req = 4'b0100;
    tick();
    chk("w_grant", 32'(ch_grant), 32'b0100);
    for (int t = 0; t < 99; t++) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    ch_req  = 4'b0000;
    chk("w_done", 32'(ch_done), 32'b0100);
    chk("w_err", 32'(ch_err), 32'd0);
    tick();
    chk("w_err_late", 32'(ch_err), 32'd0);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
